// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes init/read commands from the host and returns
// R1/R3/R7 responses and 512-byte data blocks fetched through a byte-request port.
module sd_spi_responder #(
  parameter int unsigned RESP_DELAY = 1,
  parameter int unsigned READ_DELAY = 4,
  parameter logic [31:0] OCR        = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        byte_req,
  output logic [8:0]  byte_idx,
  output logic [31:0] blk_addr,
  input  logic [7:0]  byte_data,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        idle_state
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 9;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_GAP,
    S_TRAIL,
    S_WAIT,
    S_DATA,
    S_CRC
  } state_t;

  logic [1:0]       r_ss_sync;
  logic [1:0]       r_sck_sync;
  logic [1:0]       r_mosi_sync;
  logic             r_sck_d;
  logic             w_ss;
  logic             w_mosi;
  logic             w_sck_rise;
  logic             w_sck_fall;

  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_rx_shift;
  logic             r_tx_pending;
  logic [7:0]       r_tx_shift;
  logic             r_miso;
  logic             w_rx_done;
  logic             w_load;
  logic [7:0]       w_rx_byte;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [7:0]       w_tx_byte;
  logic             w_hunt_hit;
  logic             w_arg_shift_en;
  logic             w_cmd_done;
  logic             w_fetch;
  logic             w_idx_clr;
  logic             w_idx_inc;

  logic [5:0]       r_cur_idx;
  logic [31:0]      r_arg_shift;
  logic [7:0]       r_r1;
  logic [7:0]       w_r1;
  logic             w_idle_nxt;
  logic [7:0]       w_trail_byte;
  logic             r_app_cmd;
  logic             r_idle;
  logic             r_cmd_valid;
  logic [5:0]       r_cmd_index;
  logic [31:0]      r_cmd_arg;
  logic [31:0]      r_blk_addr;

  logic             r_byte_req;
  logic             r_req_d;
  logic [IDX_W-1:0] r_byte_idx;
  logic [7:0]       r_prefetch;

  // Two-flop synchronisers for the asynchronous SPI pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ss_sync   <= 2'b11;
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b11;
      r_sck_d     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[0], spi_ss};
      r_sck_sync  <= {r_sck_sync[0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_sck_d     <= r_sck_sync[1];
    end
  end

  assign w_ss       = r_ss_sync[1];
  assign w_mosi     = r_mosi_sync[1];
  assign w_sck_rise = r_sck_sync[1] & ~r_sck_d;
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_d;
  assign w_rx_byte  = {r_rx_shift, w_mosi};
  assign w_rx_done  = w_sck_rise & ~w_ss & (r_bit_cnt == 3'd7);
  assign w_load     = w_sck_fall & ~w_ss & r_tx_pending;

  // Bit-level shifter: rx on SCK rise, tx byte load on the fall after a byte's 8th rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= 3'd0;
      r_rx_shift   <= 7'd0;
      r_tx_pending <= 1'b0;
      r_tx_shift   <= 8'hFF;
      r_miso       <= 1'b1;
    end else begin
      r_miso <= w_ss ? 1'b1 : r_tx_shift[7];
      if (w_ss) begin
        r_bit_cnt    <= 3'd0;
        r_tx_pending <= 1'b0;
        r_tx_shift   <= 8'hFF;
      end else begin
        if (w_sck_rise) begin
          r_rx_shift <= w_rx_byte[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_tx_pending <= 1'b1;
        end
        if (w_sck_fall) begin
          if (r_tx_pending) begin
            r_tx_shift   <= w_tx_byte;
            r_tx_pending <= 1'b0;
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b1};
          end
        end
      end
    end
  end

  // R1 value and idle flag update for the command being completed.
  always_comb begin
    w_r1       = {5'b0, 1'b1, 1'b0, r_idle};
    w_idle_nxt = r_idle;
    case (r_cur_idx)
      6'd0: begin
        w_r1       = 8'h01;
        w_idle_nxt = 1'b1;
      end
      6'd8, 6'd16, 6'd17, 6'd55, 6'd58: w_r1 = {7'b0, r_idle};
      6'd41: begin
        if (r_app_cmd) begin
          w_r1       = 8'h00;
          w_idle_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Trailing bytes: R7 echo for CMD8, OCR for CMD58.
  always_comb begin
    w_trail_byte = 8'h00;
    if (r_cmd_index == 6'd58) begin
      case (r_cnt[1:0])
        2'd0:    w_trail_byte = OCR[31:24];
        2'd1:    w_trail_byte = OCR[23:16];
        2'd2:    w_trail_byte = OCR[15:8];
        default: w_trail_byte = OCR[7:0];
      endcase
    end else begin
      case (r_cnt[1:0])
        2'd0, 2'd1: w_trail_byte = 8'h00;
        2'd2:       w_trail_byte = 8'h01;
        default:    w_trail_byte = r_cmd_arg[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;
  end

  // Receive side advances on rx bytes; transmit side advances on tx byte loads.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_byte      = 8'hFF;
    w_cnt_clr      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_hunt_hit     = 1'b0;
    w_arg_shift_en = 1'b0;
    w_cmd_done     = 1'b0;
    w_fetch        = 1'b0;
    w_idx_clr      = 1'b0;
    w_idx_inc      = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_rx_done && (w_rx_byte[7:6] == 2'b01)) begin
          w_hunt_hit  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (w_rx_done) begin
          if (r_cnt == CNT_W'(4)) begin
            w_cmd_done  = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_arg_shift_en = 1'b1;
            w_cnt_inc      = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_load) begin
          if (r_cnt == CNT_W'(RESP_DELAY)) begin
            w_tx_byte = r_r1;
            w_cnt_clr = 1'b1;
            if ((r_cmd_index == 6'd8) || (r_cmd_index == 6'd58)) w_state_nxt = S_TRAIL;
            else if (r_cmd_index == 6'd17)                       w_state_nxt = S_WAIT;
            else                                                 w_state_nxt = S_HUNT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (w_load) begin
          w_tx_byte = w_trail_byte;
          w_cnt_inc = 1'b1;
          if (r_cnt == CNT_W'(3)) w_state_nxt = S_HUNT;
        end
      end
      S_WAIT: begin
        if (w_load) begin
          if (r_cnt == CNT_W'(READ_DELAY)) begin
            w_tx_byte   = 8'hFE;
            w_cnt_clr   = 1'b1;
            w_fetch     = 1'b1;
            w_idx_clr   = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_load) begin
          w_tx_byte = r_prefetch;
          w_idx_inc = 1'b1;
          if (r_byte_idx == IDX_W'(511)) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_CRC;
          end else begin
            w_fetch = 1'b1;
          end
        end
      end
      S_CRC: begin
        if (w_load) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_nxt = S_HUNT;
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase
    if (w_ss) w_state_nxt = S_HUNT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (w_ss || w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc)         r_cnt <= r_cnt + CNT_W'(1);
  end

  // Command capture and card status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_idx   <= 6'd0;
      r_arg_shift <= 32'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_index <= 6'd0;
      r_cmd_arg   <= 32'd0;
      r_r1        <= 8'hFF;
      r_idle      <= 1'b1;
      r_app_cmd   <= 1'b0;
      r_blk_addr  <= 32'd0;
    end else begin
      r_cmd_valid <= w_cmd_done;
      if (w_hunt_hit)     r_cur_idx   <= w_rx_byte[5:0];
      if (w_arg_shift_en) r_arg_shift <= {r_arg_shift[23:0], w_rx_byte};
      if (w_cmd_done) begin
        r_cmd_index <= r_cur_idx;
        r_cmd_arg   <= r_arg_shift;
        r_r1        <= w_r1;
        r_idle      <= w_idle_nxt;
        r_app_cmd   <= (r_cur_idx == 6'd55);
        if (r_cur_idx == 6'd17) r_blk_addr <= r_arg_shift;
      end
    end
  end

  // Block byte fetch: request one byte ahead of the one being shifted out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_req <= 1'b0;
      r_req_d    <= 1'b0;
      r_byte_idx <= '0;
      r_prefetch <= 8'h00;
    end else begin
      r_byte_req <= w_fetch;
      r_req_d    <= r_byte_req;
      if (w_idx_clr)      r_byte_idx <= '0;
      else if (w_idx_inc) r_byte_idx <= r_byte_idx + IDX_W'(1);
      if (r_req_d) r_prefetch <= byte_data;
    end
  end

  assign spi_miso   = r_miso;
  assign byte_req   = r_byte_req;
  assign byte_idx   = r_byte_idx;
  assign blk_addr   = r_blk_addr;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_index  = r_cmd_index;
  assign cmd_arg    = r_cmd_arg;
  assign idle_state = r_idle;

endmodule
